hazard_controller: RTL
======================

Name: hazard_controller

Overview:
- Central pipeline sequencer for the 5-stage core. It drives the stall and flush controls of the IF/ID and ID/EX pipeline registers, including `id_stall_i` and `id_flush_i` of the decode stage.
- Detects load-use hazards and taken branches/jumps, and absorbs external memory wait.
- Sequences ECALL/EBREAK: stop fetch, drain older instructions, halt, resume on request.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- DRAIN_CYCLES, 2, cycles after trap detection in EX before `halted_o` asserts (lets MEM and WB retire); legal range 1..7.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous active-low reset.
- id_rs1_i  input  5  rs1 field of the instruction in ID.
- id_rs2_i  input  5  rs2 field of the instruction in ID.
- ex_rd_i  input  5  rd of the instruction in EX (ID/EX register).
- ex_read_mem_i  input  1  instruction in EX is a load.
- ex_bnj_taken_i  input  1  EX resolved a taken branch, JAL or JALR (pc redirect this cycle).
- ex_trap_i  input  1  instruction in EX is ECALL/EBREAK.
- mem_busy_i  input  1  data memory not ready; whole pipeline must freeze.
- resume_i  input  1  single-cycle pulse; leave HALTED.
- if_stall_o  output  1  hold PC and the IF/ID register.
- if_flush_o  output  1  zero the IF/ID register (bubble).
- id_stall_o  output  1  hold the ID/EX register.
- id_flush_o  output  1  zero the ID/EX register.
- ex_stall_o  output  1  hold EX/MEM and later registers.
- halted_o  output  1  core halted on trap.
- stall_cnt_o  output  CNT_W  cycles with `if_stall_o` = 1.
- flush_cnt_o  output  CNT_W  cycles with `if_flush_o` or `id_flush_o` = 1.

Behaviour:
- State machine: RUN, DRAIN, HALTED. The state register and counters reset asynchronously to RUN and 0. With reset asserted, every control output is 0.
- Load-use hazard (lu): `ex_read_mem_i` && `ex_rd_i` != 0 && (`ex_rd_i` == `id_rs1_i` || `ex_rd_i` == `id_rs2_i`). It is evaluated in the same cycle (combinational) and inserts exactly one bubble:
  - `if_stall_o` = 1, `id_flush_o` = 1.
  - The next cycle the load has moved to MEM, so lu drops and no second bubble is inserted.
- Taken branch/jump (br): `if_flush_o` = 1, `id_flush_o` = 1 for exactly the cycle `ex_bnj_taken_i` = 1. br has priority over lu: a flush never also stalls.
- `mem_busy_i` (RUN or DRAIN) has the highest priority:
  - `if_stall_o` = `id_stall_o` = `ex_stall_o` = 1.
  - All flushes are 0.
  - br, lu and trap are not acted on. EX is frozen and re-presents them once busy deasserts.
  - The DRAIN counter does not advance.
- RUN to DRAIN: `ex_trap_i` = 1 and `mem_busy_i` = 0.
  - In that cycle: `if_stall_o` = 1, `if_flush_o` = 1, `id_flush_o` = 1 (kill younger instructions).
  - Load the drain counter with DRAIN_CYCLES.
  - A trap takes priority over br and lu in the same cycle.
- DRAIN:
  - `if_stall_o` = 1, `if_flush_o` = 1, `id_flush_o` = 1 every cycle. Inputs br, lu and trap are ignored.
  - The counter decrements each non-busy cycle. When it reaches 0, go to HALTED.
- HALTED:
  - `halted_o` = 1; `if_stall_o` = 1, `if_flush_o` = 1, `id_flush_o` = 1.
  - `resume_i` moves to RUN the next cycle, and `halted_o` drops in that same cycle.
  - `resume_i` in any other state is ignored.
- `halted_o` is registered (decoded from state). All other control outputs are combinational from state and inputs, with no added latency.
- Counters:
  - Increment on the rising edge after each qualifying cycle, including DRAIN and HALTED cycles.
  - Saturate at all-ones and never wrap.
  - Cleared only by reset.
- Reset mid-DRAIN or mid-HALTED: return immediately to RUN with all outputs 0. No residual counter state.
- x0: `ex_rd_i` = 0 never causes lu, even when `id_rs1_i` or `id_rs2_i` = 0.

Decomposition:
- Shared definitions include: state encodings (`HZ_RUN`, `HZ_DRAIN`, `HZ_HALTED`) and the trap opcode constants already used by decode. No typedef beyond these.
- One sub-module is natural: `sat_counter` (parameter W; ports clk, reset_n, inc_i, count_o), instantiated twice for the performance counters.

Test Plan:
- Load-use: EX = LW x5, `ex_read_mem_i` = 1, `ex_rd_i` = 5; ID `id_rs2_i` = 5 -> one cycle of `if_stall_o` = 1, `id_flush_o` = 1, then all 0; `stall_cnt_o` goes 0 to 1. Repeat with `ex_rd_i` = 0 -> no stall.
- Branch with concurrent lu: `ex_bnj_taken_i` = 1 together with lu true -> `if_flush_o` = 1, `id_flush_o` = 1, `if_stall_o` = 0; `flush_cnt_o` +1.
- Memory wait: `mem_busy_i` = 1 for 3 cycles while `ex_bnj_taken_i` = 1 -> all three stalls = 1 and flushes = 0 for 3 cycles; flush asserts in the first cycle after busy drops.
- Trap drain: `ex_trap_i` pulse with DRAIN_CYCLES = 2 -> flushes for the trap cycle plus 2 DRAIN cycles; `halted_o` = 1 on the third edge; `resume_i` pulse -> `halted_o` = 0 the next cycle, outputs idle.
- Trap during busy: `ex_trap_i` = 1 and `mem_busy_i` = 1 for 2 cycles -> stays in RUN; DRAIN entered the first non-busy cycle; one busy cycle inside DRAIN extends the halt by 1.
- Saturation and reset: CNT_W = 3, hold lu for 10 cycles -> `stall_cnt_o` = 7 and stays at 7. Assert reset_n = 0 in HALTED -> `halted_o` = 0 and counters = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: sequencer state
// encodings and the SYSTEM opcode constants that decode uses to flag traps.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_DRAIN  = 2'd1,
    HZ_HALTED = 2'd2
  } hz_state_e;

  localparam logic [6:0]  OPC_SYSTEM   = 7'b1110011;
  localparam logic [11:0] F12_ECALL    = 12'h000;
  localparam logic [11:0] F12_EBREAK   = 12'h001;

  // Drain counter width; covers the legal DRAIN_CYCLES range 1..7.
  localparam int          DRAIN_W      = 3;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Holds at all-ones once reached; cleared only by reset.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (inc_i && !(&r_count)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: load-use bubbles, branch flushes, memory-wait freeze and
// the ECALL/EBREAK drain-and-halt sequence, plus stall/flush perf counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_read_mem_i,
  input  logic             ex_bnj_taken_i,
  input  logic             ex_trap_i,
  input  logic             mem_busy_i,
  input  logic             resume_i,
  output logic             if_stall_o,
  output logic             if_flush_o,
  output logic             id_stall_o,
  output logic             id_flush_o,
  output logic             ex_stall_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  hz_state_e          r_state;
  hz_state_e          w_state_nxt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [DRAIN_W-1:0] w_drain_nxt;

  logic w_lu;
  logic w_if_stall;
  logic w_if_flush;
  logic w_id_stall;
  logic w_id_flush;
  logic w_ex_stall;

  // x0 is never a real producer, so a load to x0 never forces a bubble.
  assign w_lu = ex_read_mem_i && (ex_rd_i != 5'd0) &&
                ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= HZ_RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    w_if_stall  = 1'b0;
    w_if_flush  = 1'b0;
    w_id_stall  = 1'b0;
    w_id_flush  = 1'b0;
    w_ex_stall  = 1'b0;

    case (r_state)
      HZ_RUN: begin
        if (mem_busy_i) begin
          w_if_stall = 1'b1;
          w_id_stall = 1'b1;
          w_ex_stall = 1'b1;
        end else if (ex_trap_i) begin
          w_if_stall  = 1'b1;
          w_if_flush  = 1'b1;
          w_id_flush  = 1'b1;
          w_state_nxt = HZ_DRAIN;
          w_drain_nxt = DRAIN_W'(DRAIN_CYCLES);
        end else if (ex_bnj_taken_i) begin
          w_if_flush = 1'b1;
          w_id_flush = 1'b1;
        end else if (w_lu) begin
          w_if_stall = 1'b1;
          w_id_flush = 1'b1;
        end
      end

      HZ_DRAIN: begin
        if (mem_busy_i) begin
          w_if_stall = 1'b1;
          w_id_stall = 1'b1;
          w_ex_stall = 1'b1;
        end else begin
          w_if_stall = 1'b1;
          w_if_flush = 1'b1;
          w_id_flush = 1'b1;
          // Last drain cycle: older instructions have retired by the next edge.
          if (r_drain_cnt <= DRAIN_W'(1)) begin
            w_drain_nxt = '0;
            w_state_nxt = HZ_HALTED;
          end else begin
            w_drain_nxt = r_drain_cnt - DRAIN_W'(1);
          end
        end
      end

      HZ_HALTED: begin
        w_if_stall = 1'b1;
        w_if_flush = 1'b1;
        w_id_flush = 1'b1;
        if (resume_i) begin
          w_state_nxt = HZ_RUN;
        end
      end

      default: begin
        w_state_nxt = HZ_RUN;
        w_drain_nxt = '0;
      end
    endcase
  end

  // Controls are forced low while reset is held, independent of the inputs.
  assign if_stall_o = reset_n & w_if_stall;
  assign if_flush_o = reset_n & w_if_flush;
  assign id_stall_o = reset_n & w_id_stall;
  assign id_flush_o = reset_n & w_id_flush;
  assign ex_stall_o = reset_n & w_ex_stall;
  assign halted_o   = (r_state == HZ_HALTED);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (if_stall_o),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (if_flush_o | id_flush_o),
    .count_o (flush_cnt_o)
  );

endmodule
